// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states and
// helpers that decode a request's width into legality, alignment and byte lanes.
package lsu_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 256;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } lsu_state_t;

    function automatic logic req_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!we) begin
            legal = legal || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return legal;
    endfunction

    function automatic logic req_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3 == F3_H || funct3 == F3_HU) begin
            mis = addr_lo[0];
        end else if (funct3 == F3_W) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow stores replicate their data so every candidate lane already holds it.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM built from four byte-lane arrays; each lane has its own
// write enable and a registered read that holds its value when no read is issued.
module data_ram
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    rdata_reg <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates a request, writes byte lanes for stores, and
// returns sign/zero-extended load data through a valid/ready response port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] mem_data,
    output logic [4:0]  rd_addr,
    output logic        reg_write_enable,
    output logic        mem_to_reg,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_t   state_reg;
    logic         we_reg;
    logic [2:0]   funct3_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]  wdata_reg;
    logic [4:0]   rd_reg;
    logic         req_ready_reg;
    logic         rsp_valid_reg;
    logic         fault_reg;

    logic [3:0]   ram_we;
    logic         ram_re;
    logic [31:0]  ram_rdata;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  load_ext;

    // Upper address bits wrap around the RAM and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_reg        <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        we_reg        <= req_we;
                        funct3_reg    <= req_funct3;
                        addr_reg      <= req_addr[AW+1:0];
                        wdata_reg     <= req_wdata;
                        rd_reg        <= req_rd;
                        req_ready_reg <= 1'b0;
                        if (!req_legal(req_we, req_funct3) ||
                            req_misaligned(req_funct3, req_addr[1:0])) begin
                            state_reg <= ERR;
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_reg) begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end else begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                ERR: begin
                    state_reg     <= IDLE;
                    fault_reg     <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    fault_reg     <= 1'b0;
                end
            endcase
        end
    end

    // A reset landing on the ACCESS edge must cancel the pending store.
    assign ram_we = (state_reg == ACCESS && we_reg && !reset) ?
                    byte_enables(funct3_reg, addr_reg[1:0]) : 4'b0000;
    assign ram_re = (state_reg == ACCESS) && !we_reg;

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_reg[AW+1:2]),
        .wdata (store_lanes(funct3_reg, wdata_reg)),
        .rdata (ram_rdata)
    );

    always_comb begin
        byte_sel = ram_rdata[{addr_reg[1:0], 3'b000} +: 8];
        half_sel = addr_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_reg)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'h000000, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'h0000, half_sel};
            default: load_ext = ram_rdata;
        endcase
    end

    assign req_ready        = req_ready_reg;
    assign rsp_valid        = rsp_valid_reg;
    assign fault            = fault_reg;
    assign mem_data         = rsp_valid_reg ? load_ext : 32'h0;
    assign rd_addr          = rsp_valid_reg ? rd_reg : 5'd0;
    assign reg_write_enable = rsp_valid_reg && rsp_ready;
    assign mem_to_reg       = rsp_valid_reg && rsp_ready;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle reset
// sequences and random traffic checked against a byte-array memory model.
module tb_load_store_unit;

    localparam int DEPTH = 256;
    localparam int MEMB  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] mem_data;
    logic [4:0]  rd_addr;
    logic        reg_write_enable;
    logic        mem_to_reg;
    logic        fault;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .mem_data         (mem_data),
        .rd_addr          (rd_addr),
        .reg_write_enable (reg_write_enable),
        .mem_to_reg       (mem_to_reg),
        .fault            (fault)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [MEMB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd2:       return 4;
            3'd1, 3'd5: return 2;
            default:    return 1;
        endcase
    endfunction

    function automatic bit model_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || ((a % acc_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int base;
        logic [31:0] v;
        n = acc_size(f3);
        base = int'(a % MEMB);
        v = 32'h0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[base + i]) << (8 * i);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int base;
        base = int'(a % MEMB);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[base + i] = 8'(d >> (8 * i));
    endtask

    // ---------------- transaction driver ----------------
    task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE (back-to-back capable).
    task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int hold,
                        input bit exp_fault, input logic [31:0] exp_data);
        drive(we, f3, addr, wdata, rd);
        rsp_ready = 1'b0;
        check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_fault) begin
            check("fault_pulse", fault, 1);
            check("fault_no_rsp", rsp_valid, 0);
            check("fault_busy", req_ready, 0);
            @(negedge clk);
            check("fault_drop", fault, 0);
            check("fault_no_rsp2", rsp_valid, 0);
        end else if (we) begin
            check("st_busy", req_ready, 0);
            check("st_no_fault", fault, 0);
            check("st_no_rsp", rsp_valid, 0);
            @(negedge clk);
            model_store(f3, addr, wdata);
        end else begin
            check("ld_access_no_rsp", rsp_valid, 0);
            check("ld_no_fault", fault, 0);
            @(negedge clk);
            check("ld_rsp_valid", rsp_valid, 1);
            check("ld_data", mem_data, exp_data);
            check("ld_rd", rd_addr, rd);
            check("ld_no_we", reg_write_enable, 0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", rsp_valid, 1);
                check("hold_data", mem_data, exp_data);
                check("hold_rd", rd_addr, rd);
                check("hold_busy", req_ready, 0);
                check("hold_no_we", reg_write_enable, 0);
            end
            rsp_ready = 1'b1;
            #1;
            check("hs_we", reg_write_enable, 1);
            check("hs_m2r", mem_to_reg, 1);
            @(negedge clk);
            rsp_ready = 1'b0;
            check("post_hs_valid", rsp_valid, 0);
            check("post_hs_we", reg_write_enable, 0);
        end
        $display("xact we=%0d f3=%0d addr=%h wdata=%h rd=%0d hold=%0d fault=%0d data=%h",
                 we, f3, addr, wdata, rd, hold, exp_fault, exp_data);
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          hold;
        bit          fault;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] old;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          bad;

        vecs[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 5'd0,  0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        5'd5,  0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 3'd0, 32'h13,   32'h0,        5'd7,  0, 1'b0, 32'hFFFFFFDE};
        vecs[3]  = '{1'b0, 3'd4, 32'h13,   32'h0,        5'd8,  1, 1'b0, 32'h000000DE};
        vecs[4]  = '{1'b0, 3'd1, 32'h12,   32'h0,        5'd9,  0, 1'b0, 32'hFFFFDEAD};
        vecs[5]  = '{1'b0, 3'd5, 32'h10,   32'h0,        5'd10, 0, 1'b0, 32'h0000BEEF};
        vecs[6]  = '{1'b1, 3'd0, 32'h11,   32'hAABBCC55, 5'd0,  0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 3'd2, 32'h10,   32'h0,        5'd11, 0, 1'b0, 32'hDEAD55EF};
        vecs[8]  = '{1'b0, 3'd2, 32'h12,   32'h0,        5'd12, 0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 3'd3, 32'h10,   32'h0,        5'd13, 0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 3'd4, 32'h10,   32'h11111111, 5'd0,  0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'h13,   32'h22222222, 5'd0,  0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 3'd2, 32'h10,   32'h0,        5'd0,  5, 1'b0, 32'hDEAD55EF};
        vecs[13] = '{1'b0, 3'd2, 32'h1010, 32'h0,        5'd31, 0, 1'b0, 32'hDEAD55EF};
        vecs[14] = '{1'b1, 3'd2, 32'h14,   32'h00000000, 5'd0,  0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 3'd1, 32'h16,   32'hFFFF1234, 5'd0,  0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 3'd2, 32'h14,   32'h0,        5'd4,  0, 1'b0, 32'h12340000};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_we", reg_write_enable, 0);
        check("rst_m2r", mem_to_reg, 0);
        check("rst_data", mem_data, 0);
        check("rst_rd", rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // give every word a known value so the model and RAM agree everywhere
        for (int w = 0; w < DEPTH; w++) xact(1'b1, 3'd2, 32'(w * 4), $urandom, 5'd0, 0, 1'b0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                 vecs[i].hold, vecs[i].fault, vecs[i].data);
        end

        // reset while a store is in ACCESS: the store must be dropped
        old = model_load(3'd2, 32'h20);
        drive(1'b1, 3'd2, 32'h20, 32'h00001234, 5'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstacc_busy", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstacc_ready", req_ready, 1);
        check("rstacc_rsp_valid", rsp_valid, 0);
        check("rstacc_fault", fault, 0);
        check("rstacc_data", mem_data, 0);
        check("rstacc_rd", rd_addr, 0);
        $display("xact reset during store ACCESS addr=00000020");
        xact(1'b0, 3'd2, 32'h20, 32'h0, 5'd6, 0, 1'b0, old);

        // reset while a load response is pending
        drive(1'b0, 3'd2, 32'h10, 32'h0, 5'd3);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstresp_valid_before", rsp_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstresp_valid", rsp_valid, 0);
        check("rstresp_data", mem_data, 0);
        check("rstresp_rd", rd_addr, 0);
        check("rstresp_ready", req_ready, 1);
        $display("xact reset during load RESP addr=00000010");

        // random traffic against the model
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = ($urandom_range(0, 4) < 3) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
            bad = model_bad(we, f3, addr);
            xact(we, f3, addr, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3), bad,
                 (we || bad) ? 32'h0 : model_load(f3, addr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
